seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), with clock and reset listed first:
- clk  input  1  single system clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-high.
- start  input  1  request a division; sampled only in IDLE.
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
- dividend  input  32  numerator, from the Y register; sampled with start.
- divisor  input  32  denominator, from the bus; sampled with start.
- quotient  output  32  result for ZLO.
- remainder  output  32  result for ZHI.
- busy  output  1  high from the edge that accepts start until done drops.
- done  output  1  one-cycle pulse; results valid.
- div_by_zero  output  1  set when the last accepted divisor was 0.

Function
REQ-002 The FSM SHALL have the states IDLE, ITER, FIX and DONE, with the following transitions.
- IDLE to ITER on a clk edge with start=1 and divisor!=0.
- IDLE to DONE on a clk edge with start=1 and divisor==0.
- ITER to FIX after exactly 32 iteration edges.
- FIX to DONE after one edge.
- DONE to IDLE after one edge.
REQ-003 On accept, the block SHALL latch |dividend| and |divisor| when signed_op=1, or the raw values when signed_op=0; it SHALL also latch the two sign bits, clear a 6-bit iteration counter, and clear the 33-bit partial remainder.
REQ-004 In ITER, each edge SHALL perform one restoring shift-subtract step, producing one quotient bit, MSB first.
REQ-005 In FIX, the block SHALL apply sign correction.
- Quotient is negated when the latched sign bits differ.
- Remainder is negated when the latched dividend sign is 1.
- Both are then registered onto quotient and remainder.
REQ-006 Latency SHALL be fixed.
- done is high for exactly one cycle, during the cycle after the 34th clk edge following the accepting edge.
- Divide-by-zero case: done is high during the cycle after the 1st edge following the accepting edge.
REQ-007 quotient, remainder and div_by_zero SHALL be valid when done=1 and SHALL hold until the next accepted start.
REQ-008 busy SHALL be 1 in ITER, FIX and DONE, and 0 in IDLE.
REQ-009 Divide by zero SHALL produce quotient=32'hFFFFFFFF, remainder=dividend (the unmodified input) and div_by_zero=1; any accepted start with a nonzero divisor SHALL clear div_by_zero.
REQ-010 For a signed 32'h80000000 / 32'hFFFFFFFF, the block SHALL produce quotient=32'h80000000 and remainder=0 (wrap, no flag).
REQ-011 start asserted while busy=1 SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-012 start held high continuously SHALL launch a new operation on the first edge in IDLE after DONE, with inputs sampled at that edge.
REQ-013 Results SHALL satisfy dividend = quotient*divisor + remainder (mod 2^32), with |remainder| < |divisor|.

Reset
REQ-014 clr=1 SHALL immediately, with no clock required, force the following.
- State to IDLE.
- quotient, remainder and the internal registers to 0.
- busy, done and div_by_zero to 0.
REQ-015 clr asserted mid-operation SHALL abort the division with no done pulse; the block SHALL accept start on the first edge after clr deasserts.

Configuration
REQ-016 The macro DIV_SIGNED_EN SHALL control signed support.
- Defined: signed_op is honoured per REQ-003, REQ-005 and REQ-010.
- Not defined: the sign logic is compiled out, signed_op is ignored, all operations are unsigned, and the port list is unchanged.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Unsigned, dividend=32'h18, divisor=32'h14 -> quotient=1, remainder=4; done exactly 34 edges after accept; busy high throughout.
- Unsigned, 100 / 7 -> quotient=14, remainder=2.
- DIV_SIGNED_EN defined, signed_op=1, -7 / 2 -> quotient=32'hFFFFFFFD, remainder=32'hFFFFFFFF.
- divisor=0, dividend=32'h12 -> quotient=32'hFFFFFFFF, remainder=32'h12, div_by_zero=1, done 1 edge after accept; then 8/2 -> div_by_zero=0.
- Second start pulse 5 cycles into an operation with new operands -> first result unchanged, only one done pulse.
- clr pulsed 10 cycles into an operation -> all outputs 0 immediately, no done pulse; a following 9/3 -> quotient=3, remainder=0.

Source files
------------

// File: rtl/seq_divider.sv
// 32-bit restoring sequential divider, one quotient bit per clock; DIV_SIGNED_EN enables signed operands.
// Fixed latency: done pulses 34 edges after accept (1 edge for divide-by-zero); start is ignored while busy.
module seq_divider (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t      state;
    logic [31:0] q_sh;
    logic [31:0] d_reg;
    logic [32:0] rem;
    logic [5:0]  cnt;
    logic [33:0] diff;
    logic [31:0] a_in;
    logic [31:0] d_in;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic        accept;

    assign accept = (state == IDLE) && start;
    // The shifted-in partial remainder minus the divisor; bit 33 set means the subtract failed.
    assign diff   = {rem, q_sh[31]} - {2'b00, d_reg};

`ifdef DIV_SIGNED_EN
    logic sign_a;
    logic sign_d;
    logic neg_a;
    logic neg_d;

    assign neg_a = signed_op & dividend[31];
    assign neg_d = signed_op & divisor[31];
    assign a_in  = neg_a ? -dividend : dividend;
    assign d_in  = neg_d ? -divisor : divisor;
    assign q_fix = (sign_a ^ sign_d) ? -q_sh : q_sh;
    assign r_fix = sign_a ? -rem[31:0] : rem[31:0];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sign_a <= 1'b0;
            sign_d <= 1'b0;
        end else if (accept) begin
            sign_a <= neg_a;
            sign_d <= neg_d;
        end
    end
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign a_in  = dividend;
    assign d_in  = divisor;
    assign q_fix = q_sh;
    assign r_fix = rem[31:0];
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            q_sh        <= '0;
            d_reg       <= '0;
            rem         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            // done trails the DONE state by one cycle; busy spans accept through the done cycle.
            done <= (state == DONE);
            if (accept)
                busy <= 1'b1;
            else if (done)
                busy <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == 32'd0) begin
                            quotient    <= 32'hFFFF_FFFF;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            q_sh        <= a_in;
                            d_reg       <= d_in;
                            rem         <= '0;
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
                            state       <= ITER;
                        end
                    end
                end
                ITER: begin
                    if (!diff[33]) begin
                        rem  <= diff[32:0];
                        q_sh <= {q_sh[30:0], 1'b1};
                    end else begin
                        rem  <= {rem[31:0], q_sh[31]};
                        q_sh <= {q_sh[30:0], 1'b0};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31)
                        state <= FIX;
                end
                FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    state     <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: latency, results, divide-by-zero, ignored start, held start, clr abort.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int total = 0;
    int bad = 0;

    seq_divider dut (
        .clk(clk), .clr(clr), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .quotient(quotient),
        .remainder(remainder), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Launches one operation and waits (bounded) for done; returns results, edge count and follow-up done.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r, output logic z,
                           output int lat, output int busy_lo, output logic done_after);
        @(negedge clk);
        dividend = a; divisor = b; signed_op = s; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_lo = 0;
        while (!done && lat < 60) begin
            if (!busy) busy_lo++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!busy) busy_lo++;
        q = quotient; r = remainder; z = div_by_zero;
        @(posedge clk);
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        #2 clr = 1'b1;
        #1;
        total++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 67'd0) begin
            bad++;
            $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_unsigned_basic();
        logic [31:0] q, r; logic z, da; int lat, blo;
        run_div(32'h18, 32'h14, 1'b0, q, r, z, lat, blo, da);
        total++;
        if (q !== 32'd1 || r !== 32'd4) begin
            bad++; $display("FAIL u24_20: got q=%h r=%h, want q=1 r=4", q, r);
        end
        total++;
        if (lat !== 34) begin
            bad++; $display("FAIL latency34: got %0d edges, want 34", lat);
        end
        total++;
        if (blo !== 0) begin
            bad++; $display("FAIL busy_during_op: busy low in %0d cycles, want 0", blo);
        end
        total++;
        if (da !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL done_width: done after=%b busy after=%b, want 0 0", da, busy);
        end
        total++;
        if (z !== 1'b0) begin
            bad++; $display("FAIL u24_dbz: got %b, want 0", z);
        end
    endtask

    task automatic test_unsigned_100_7();
        logic [31:0] q, r; logic z, da; int lat, blo;
        run_div(32'd100, 32'd7, 1'b0, q, r, z, lat, blo, da);
        total++;
        if (q !== 32'd14 || r !== 32'd2) begin
            bad++; $display("FAIL u100_7: got q=%0d r=%0d, want q=14 r=2", q, r);
        end
    endtask

    task automatic test_signed();
        logic [31:0] q, r; logic z, da; int lat, blo;
`ifdef DIV_SIGNED_EN
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, z, lat, blo, da);
        total++;
        if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL s_m7_2: got q=%h r=%h, want q=fffffffd r=ffffffff", q, r);
        end
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, z, lat, blo, da);
        total++;
        if (q !== 32'h8000_0000 || r !== 32'd0 || z !== 1'b0) begin
            bad++; $display("FAIL s_overflow: got q=%h r=%h z=%b, want q=80000000 r=0 z=0", q, r, z);
        end
`else
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, z, lat, blo, da);
        total++;
        if (q !== 32'h7FFF_FFFC || r !== 32'd1) begin
            bad++; $display("FAIL signed_ignored: got q=%h r=%h, want q=7ffffffc r=1", q, r);
        end
`endif
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r; logic z, da; int lat, blo;
        run_div(32'h12, 32'd0, 1'b0, q, r, z, lat, blo, da);
        total++;
        if (q !== 32'hFFFF_FFFF || r !== 32'h12 || z !== 1'b1) begin
            bad++; $display("FAIL dz_result: got q=%h r=%h z=%b, want ffffffff 12 1", q, r, z);
        end
        total++;
        if (lat !== 1 || da !== 1'b0) begin
            bad++; $display("FAIL dz_latency: got %0d edges done_after=%b, want 1 0", lat, da);
        end
        run_div(32'd8, 32'd2, 1'b0, q, r, z, lat, blo, da);
        total++;
        if (q !== 32'd4 || r !== 32'd0 || z !== 1'b0) begin
            bad++; $display("FAIL dz_clear: got q=%0d r=%0d z=%b, want 4 0 0", q, r, z);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0; int when = -1; logic [31:0] q = '0, r = '0;
        @(negedge clk);
        dividend = 32'd50; divisor = 32'd5; signed_op = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 5) begin
                start = 1'b1; dividend = 32'd77; divisor = 32'd3;
            end
            if (i == 6) start = 1'b0;
            if (done) begin
                pulses++;
                if (when < 0) begin when = i; q = quotient; r = remainder; end
            end
        end
        total++;
        if (pulses !== 1 || when !== 34) begin
            bad++; $display("FAIL b2b_pulses: got %0d pulses first at %0d, want 1 at 34", pulses, when);
        end
        total++;
        if (q !== 32'd10 || r !== 32'd0) begin
            bad++; $display("FAIL b2b_result: got q=%0d r=%0d, want 10 0", q, r);
        end
    endtask

    task automatic test_start_held();
        int gap = 0; logic [31:0] q1, r1;
        @(negedge clk);
        dividend = 32'd40; divisor = 32'd4; signed_op = 1'b0; start = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        q1 = quotient; r1 = remainder;
        dividend = 32'd21;
        do begin
            @(posedge clk);
            @(negedge clk);
            gap++;
        end while (!done && gap < 60);
        start = 1'b0;
        total++;
        if (q1 !== 32'd10 || r1 !== 32'd0) begin
            bad++; $display("FAIL held_first: got q=%0d r=%0d, want 10 0", q1, r1);
        end
        total++;
        if (gap !== 35 || quotient !== 32'd5 || remainder !== 32'd1) begin
            bad++; $display("FAIL held_second: got gap=%0d q=%0d r=%0d, want 35 5 1", gap, quotient, remainder);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clr_abort();
        int pulses = 0; logic [31:0] q, r; logic z, da; int lat, blo;
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        clr = 1'b1;
        #1;
        total++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 67'd0) begin
            bad++;
            $display("FAIL clr_async: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++; $display("FAIL clr_no_done: got %0d pulses, want 0", pulses);
        end
        run_div(32'd9, 32'd3, 1'b0, q, r, z, lat, blo, da);
        total++;
        if (q !== 32'd3 || r !== 32'd0 || lat !== 34) begin
            bad++; $display("FAIL clr_recover: got q=%0d r=%0d lat=%0d, want 3 0 34", q, r, lat);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_unsigned_100_7();
        test_signed();
        test_div_zero();
        test_back_to_back();
        test_start_held();
        test_clr_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
